poly_feeder: RTL and testbench
==============================

# poly_feeder

Upstream sequencer for the polynomial evaluator (`part2`), which computes A·x² + B·x + C. It accepts one operand set {A, B, C, X} per valid/ready handshake. It replays the set to the evaluator as the four serial `Go`-strobed byte loads the evaluator expects. It then captures the evaluator's result and presents it downstream on a valid/ready output, with a timeout flag if no result arrives.

## Interface
- `GO_HIGH_CYCLES`, default 2: cycles `eval_go` is held high per operand. Must be ≥1.
- `GO_LOW_CYCLES`, default 2: cycles `eval_go` is held low after each high phase. Must be ≥1.
- `TIMEOUT_CYCLES`, default 32: maximum cycles spent in WAIT_RES before giving up. Must be ≥8.

- `Clock`  in  1  single clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high. Shared with the evaluator.
- `in_valid`  in  1  operand set offered.
- `in_ready`  out  1  feeder can accept an operand set.
- `in_a`, `in_b`, `in_c`, `in_x`  in  8 each  operands, sampled on accept.
- `eval_go`  out  1  drives evaluator `Go`.
- `eval_data`  out  8  drives evaluator `DataIn`.
- `eval_result`  in  8  from evaluator `DataResult`.
- `eval_result_valid`  in  1  from evaluator `ResultValid`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  8  captured result; 0 on timeout.
- `out_timeout`  out  1  qualifies `out_result`; 1 means no result was seen.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, GO_HI, GO_LO, WAIT_RES, OUT.
- **Internal registers:**
  - operand regs `op[0..3]`, loaded as A, B, C, X;
  - 2-bit index `idx`;
  - phase counter sized for max(GO_HIGH_CYCLES, GO_LOW_CYCLES, TIMEOUT_CYCLES).
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch all four operands, set `idx`=0, clear the counter, go to GO_HI.
- **GO_HI:**
  - `eval_go`=1, `eval_data`=`op[idx]`.
  - After GO_HIGH_CYCLES cycles, go to GO_LO.
- **GO_LO:**
  - `eval_go`=0, `eval_data`=`op[idx]` (held, not changed).
  - After GO_LOW_CYCLES cycles: if `idx`<3, increment `idx` and go to GO_HI; if `idx`==3, go to WAIT_RES with the counter cleared.
- **WAIT_RES:**
  - `eval_go`=0, `eval_data`=`op[3]`.
  - On the first cycle `eval_result_valid`=1: register `eval_result` into `out_result`, set `out_timeout`=0, go to OUT.
  - If TIMEOUT_CYCLES cycles elapse without it: set `out_result`=0, `out_timeout`=1, go to OUT.
  - Valid and timeout in the same cycle: valid wins.
- **OUT:**
  - `out_valid`=1; `out_result` and `out_timeout` held stable.
  - On `out_ready`=1: go to IDLE.
  - `in_ready`=0, so no new set is accepted until the cycle after the OUT handshake.
- **Evaluator protocol:**
  - The evaluator loads `DataIn` at the rising edge where it first sees `Go` high.
  - `eval_data` therefore becomes valid no later than the first GO_HI cycle and is held through GO_LO.
- **Arithmetic:** the feeder performs none. `out_result` is the evaluator's 8-bit result (wraps mod 256).
- **Outputs:** `eval_go`, `in_ready`, `out_valid`, `busy` are decoded from state only. `eval_data`, `out_result`, `out_timeout` are registered.

## Timing
- **Reset values:**
  - state IDLE;
  - `eval_go`=0, `eval_data`=0;
  - `out_valid`=0, `out_result`=0, `out_timeout`=0;
  - `busy`=0;
  - `in_ready`=1 from the first cycle after Reset deasserts.
- **Reset mid-operation** (any state): return to IDLE next edge, drop `eval_go` and `out_valid`, discard operands. The evaluator resets simultaneously, so no partial load survives.
- **Load phase length:** 4·(GO_HIGH_CYCLES+GO_LOW_CYCLES) cycles; 16 with defaults.
- **Evaluator compute:** `eval_result_valid` rises 6 cycles after the first GO_LO cycle of X (X_WAIT→CYCLE_0..4→LOAD_A).
- **End-to-end, defaults, accept in cycle 0:**
  - GO_HI cycles 1–2 (A), 5–6 (B), 9–10 (C), 13–14 (X);
  - WAIT_RES cycles 17–21, capture at end of 21;
  - `out_valid` first high in cycle 22.
- **Stale valid:** `eval_result_valid` high from a previous result is already low before WAIT_RES, because it drops at the A load. No stale capture is possible.
- **Downstream stall:** `out_valid` may stay high indefinitely. Nothing changes until `out_ready`.

## Test plan
- Bench uses a protocol-accurate behavioural evaluator returning (A·X·X+B·X+C) mod 256.
- **Basic:** Reset, then offer A=2, B=3, C=4, X=5 → `eval_go` pulses 2 high/2 low ×4 with `eval_data` 2,3,4,5; `out_valid` in cycle 22; `out_result`=69; `out_timeout`=0.
- **Overflow:** A=10, B=0, C=0, X=10 → `out_result`=232 (1000 mod 256).
- **Back-to-back with stall:** `out_ready`=0 for 10 cycles after `out_valid`, then 1 → `out_result` stable throughout. Second set (1,1,1,1) is accepted only after the handshake; result 3.
- **Timeout:** evaluator model never asserts valid → `out_valid` with `out_timeout`=1 and `out_result`=0 after the 16-cycle load phase plus 32 cycles in WAIT_RES.
- **Reset mid-load:** assert Reset during the GO_HI of C → `eval_go`=0 and `busy`=0 next cycle. A fresh set (2,3,4,5) then yields 69.
- **Parameters:** GO_HIGH_CYCLES=1, GO_LOW_CYCLES=3 → single-cycle `eval_go` pulses spaced 4 apart; result still 69 for (2,3,4,5).

Source files
------------

// File: rtl/poly_feeder_if.sv
// Operand, evaluator and result signals of poly_feeder; master is the feeder side.
interface poly_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_c;
  logic [7:0] in_x;
  logic       eval_go;
  logic [7:0] eval_data;
  logic [7:0] eval_result;
  logic       eval_result_valid;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_timeout;
  logic       busy;

  modport master (
    input  in_valid, in_a, in_b, in_c, in_x, eval_result, eval_result_valid, out_ready,
    output in_ready, eval_go, eval_data, out_valid, out_result, out_timeout, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, in_x, eval_result, eval_result_valid, out_ready,
    input  in_ready, eval_go, eval_data, out_valid, out_result, out_timeout, busy
  );
endinterface

// File: rtl/poly_feeder.sv
// Replays one {A,B,C,X} set to the evaluator as four Go-strobed loads, then returns its result
// (22 cycles accept-to-out_valid with defaults); one set in flight, out_valid held until out_ready.
module poly_feeder #(
  parameter int GO_HIGH_CYCLES = 2,
  parameter int GO_LOW_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  poly_feeder_if.master bus
);
  localparam int MAX_HL  = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
  localparam int MAX_CYC = (MAX_HL > TIMEOUT_CYCLES) ? MAX_HL : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] HI_LAST = CW'(GO_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(GO_LOW_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GO_HI, GO_LO, WAIT_RES, OUT} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [7:0]    op [4];

  assign idx_nxt = idx + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.in_valid) state_next = GO_HI;
      GO_HI:    if (cnt == HI_LAST) state_next = GO_LO;
      GO_LO:    if (cnt == LO_LAST) state_next = (idx == 2'd3) ? WAIT_RES : GO_HI;
      WAIT_RES: if (bus.eval_result_valid || cnt == TO_LAST) state_next = OUT;
      OUT:      if (bus.out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.eval_go   = (state == GO_HI);
    bus.out_valid = (state == OUT);
    bus.busy      = (state != IDLE);
  end

  // The phase counter restarts on every state change, so each phase counts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      idx             <= 2'd0;
      for (int i = 0; i < 4; i++) op[i] <= 8'd0;
      bus.eval_data   <= 8'd0;
      bus.out_result  <= 8'd0;
      bus.out_timeout <= 1'b0;
    end else begin
      if (state_next != state)
        cnt <= '0;
      else if (state == GO_HI || state == GO_LO || state == WAIT_RES)
        cnt <= cnt + CW'(1);

      if (state == IDLE && bus.in_valid) begin
        op[0]         <= bus.in_a;
        op[1]         <= bus.in_b;
        op[2]         <= bus.in_c;
        op[3]         <= bus.in_x;
        idx           <= 2'd0;
        bus.eval_data <= bus.in_a;
      end

      // Next operand is put on the bus before its GO_HI so the evaluator sees it stable.
      if (state == GO_LO && state_next == GO_HI) begin
        idx           <= idx_nxt;
        bus.eval_data <= op[idx_nxt];
      end

      if (state == WAIT_RES && state_next == OUT) begin
        bus.out_result  <= bus.eval_result_valid ? bus.eval_result : 8'd0;
        bus.out_timeout <= ~bus.eval_result_valid;
      end
    end
  end
endmodule

// File: tb/tb_poly_feeder.sv
// Self-checking bench for poly_feeder: vector table, corner sequences and random sets against
// a behavioural evaluator and an arithmetic polynomial model.
module tb_poly_feeder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  poly_feeder_if if0();
  poly_feeder_if if1();

  poly_feeder #(.GO_HIGH_CYCLES(2), .GO_LOW_CYCLES(2), .TIMEOUT_CYCLES(32))
    dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  poly_feeder #(.GO_HIGH_CYCLES(1), .GO_LOW_CYCLES(3), .TIMEOUT_CYCLES(32))
    dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  int nchecks = 0;
  int nfail   = 0;

  // Behavioural evaluator: loads on a rising Go, result valid 6 cycles after X's Go falls.
  logic       ev_go   [2];
  logic [7:0] ev_din  [2];
  logic       ev_en   [2];
  logic       ev_prev [2];
  int         ev_k    [2];
  int         ev_cnt  [2];
  logic [7:0] ev_op   [2][4];
  logic       ev_vld  [2];
  logic [7:0] ev_res  [2];

  assign ev_go[0]  = if0.eval_go;
  assign ev_go[1]  = if1.eval_go;
  assign ev_din[0] = if0.eval_data;
  assign ev_din[1] = if1.eval_data;
  assign if0.eval_result       = ev_res[0];
  assign if0.eval_result_valid = ev_vld[0];
  assign if1.eval_result       = ev_res[1];
  assign if1.eval_result_valid = ev_vld[1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ev_prev[i] <= 1'b0;
        ev_k[i]    <= 0;
        ev_cnt[i]  <= 0;
        ev_vld[i]  <= 1'b0;
        ev_res[i]  <= 8'd0;
      end else begin
        ev_prev[i] <= ev_go[i];
        if (ev_go[i] && !ev_prev[i]) begin
          int kk;
          kk = (ev_k[i] >= 4) ? 0 : ev_k[i];
          ev_op[i][kk] <= ev_din[i];
          ev_k[i]      <= kk + 1;
          if (kk == 0) ev_vld[i] <= 1'b0;
        end
        if (!ev_go[i] && ev_prev[i] && ev_k[i] == 4 && ev_en[i]) begin
          ev_cnt[i] <= 5;
        end else if (ev_cnt[i] > 0) begin
          ev_cnt[i] <= ev_cnt[i] - 1;
          if (ev_cnt[i] == 1) begin
            ev_vld[i] <= 1'b1;
            ev_res[i] <= 8'(int'(ev_op[i][0]) * int'(ev_op[i][3]) * int'(ev_op[i][3])
                          + int'(ev_op[i][1]) * int'(ev_op[i][3]) + int'(ev_op[i][2]));
          end
        end
      end
    end
  end

  function automatic logic [7:0] poly(input logic [7:0] a, b, c, x);
    int r;
    r = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
    return 8'(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with dut0 in IDLE (or about to be).
  task automatic run0(input logic [7:0] a, b, c, x, input int exp_lat, input logic [7:0] exp_r,
                      input logic exp_to, input int stall, input bit offer_next, input string tag);
    logic [7:0] ops [4];
    int cyc;
    bit seen;
    bit stable;
    ops = '{a, b, c, x};
    if0.in_a = a; if0.in_b = b; if0.in_c = c; if0.in_x = x;
    if0.in_valid = 1'b1;
    chk({tag, "_in_ready"}, int'(if0.in_ready), 1);
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    if0.in_a = 8'($urandom); if0.in_b = 8'($urandom); if0.in_c = 8'($urandom); if0.in_x = 8'($urandom);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 200) begin
      @(negedge clk);
      if (cyc <= 16) begin
        chk({tag, "_go"},   int'(if0.eval_go),   int'(((cyc - 1) % 4) < 2));
        chk({tag, "_data"}, int'(if0.eval_data), int'(ops[(cyc - 1) / 4]));
      end
      if (if0.out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_latency"}, seen ? cyc : -1, exp_lat);
    chk({tag, "_result"},  int'(if0.out_result),  int'(exp_r));
    chk({tag, "_timeout"}, int'(if0.out_timeout), int'(exp_to));
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (offer_next) begin
        if0.in_a = 8'd1; if0.in_b = 8'd1; if0.in_c = 8'd1; if0.in_x = 8'd1;
        if0.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      @(negedge clk);
      if (!(if0.out_valid && if0.out_result == exp_r && if0.out_timeout == exp_to
            && !if0.in_ready && if0.busy)) stable = 1'b0;
    end
    if (stall > 0) chk({tag, "_stall_hold"}, int'(stable), 1);
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_out_valid"}, int'(if0.out_valid), 0);
    chk({tag, "_post_busy"},      int'(if0.busy),      0);
  endtask

  typedef struct {
    logic [7:0] a, b, c, x, r;
    logic       to;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    int cyc;
    vecs[0] = '{8'd2,   8'd3,   8'd4,   8'd5,   8'd69,  1'b0};
    vecs[1] = '{8'd10,  8'd0,   8'd0,   8'd10,  8'd232, 1'b0};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0};
    vecs[4] = '{8'd7,   8'd0,   8'd9,   8'd3,   8'd72,  1'b0};

    reset = 1'b1;
    ev_en[0] = 1'b1; ev_en[1] = 1'b1;
    if0.in_valid = 1'b0; if0.out_ready = 1'b0;
    if0.in_a = 8'd0; if0.in_b = 8'd0; if0.in_c = 8'd0; if0.in_x = 8'd0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0;
    if1.in_a = 8'd0; if1.in_b = 8'd0; if1.in_c = 8'd0; if1.in_x = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",    int'(if0.in_ready),    1);
    chk("rst_busy",        int'(if0.busy),        0);
    chk("rst_eval_go",     int'(if0.eval_go),     0);
    chk("rst_eval_data",   int'(if0.eval_data),   0);
    chk("rst_out_valid",   int'(if0.out_valid),   0);
    chk("rst_out_result",  int'(if0.out_result),  0);
    chk("rst_out_timeout", int'(if0.out_timeout), 0);

    for (int i = 0; i < 5; i++)
      run0(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x, 22, vecs[i].r, vecs[i].to, 0, 1'b0,
           $sformatf("vec%0d", i));

    // Downstream stall with a second set waiting; it may only enter after the handshake.
    run0(8'd2, 8'd3, 8'd4, 8'd5, 22, 8'd69, 1'b0, 10, 1'b1, "stall");
    run0(8'd1, 8'd1, 8'd1, 8'd1, 22, 8'd3,  1'b0, 0,  1'b0, "b2b");

    ev_en[0] = 1'b0;
    run0(8'd2, 8'd3, 8'd4, 8'd5, 49, 8'd0, 1'b1, 3, 1'b0, "timeout");
    ev_en[0] = 1'b1;

    // Reset during the GO_HI of C.
    if0.in_a = 8'd2; if0.in_b = 8'd3; if0.in_c = 8'd4; if0.in_x = 8'd5;
    if0.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("midrst_pre_go",   int'(if0.eval_go),   1);
    chk("midrst_pre_data", int'(if0.eval_data), 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_go",       int'(if0.eval_go),   0);
    chk("midrst_busy",     int'(if0.busy),      0);
    chk("midrst_in_ready", int'(if0.in_ready),  1);
    chk("midrst_data",     int'(if0.eval_data), 0);
    run0(8'd2, 8'd3, 8'd4, 8'd5, 22, 8'd69, 1'b0, 0, 1'b0, "after_rst");

    // Short-high / long-low pacing: single-cycle Go pulses every 4 cycles.
    begin
      logic [7:0] ops1 [4];
      ops1 = '{8'd2, 8'd3, 8'd4, 8'd5};
      if1.in_a = 8'd2; if1.in_b = 8'd3; if1.in_c = 8'd4; if1.in_x = 8'd5;
      if1.in_valid = 1'b1;
      chk("p13_in_ready", int'(if1.in_ready), 1);
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      cyc = 1;
      seen = 1'b0;
      while (!seen && cyc <= 200) begin
        @(negedge clk);
        if (cyc <= 16) begin
          chk("p13_go",   int'(if1.eval_go),   int'(((cyc - 1) % 4) == 0));
          chk("p13_data", int'(if1.eval_data), int'(ops1[(cyc - 1) / 4]));
        end
        if (if1.out_valid) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          cyc++;
        end
      end
      chk("p13_latency", seen ? cyc : -1, 21);
      chk("p13_result",  int'(if1.out_result),  69);
      chk("p13_timeout", int'(if1.out_timeout), 0);
      if1.out_ready = 1'b1;
      @(posedge clk); #1;
      if1.out_ready = 1'b0;
      @(negedge clk);
      chk("p13_post_busy", int'(if1.busy), 0);
    end

    for (int n = 0; n < 16; n++) begin
      logic [7:0] ra, rb, rc, rx;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      rx = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run0(ra, rb, rc, rx, 22, poly(ra, rb, rc, rx), 1'b0, $urandom_range(0, 4), 1'b0,
           $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
